puf_sig_sequencer: RTL and testbench
====================================

# puf_sig_sequencer

Sequencer for the RO-PUF signature datapath: the RO pair banks, the challenge-selected muxes, the pair of RO-clocked counters, the comparator and the signature RAM. On `start` it sweeps every challenge and, for each one, runs a fixed reset/count/settle window on the counters. It samples the comparator bit, packs bits into `WORD_W`-bit words, writes each completed word to RAM and pulses `done` when the sweep is finished.

## Interface
- `N_CHAL`, default 256: number of challenges swept; must be a multiple of `WORD_W`.
- `CHAL_W`, default 8: challenge width; `2^CHAL_W >= N_CHAL`.
- `WORD_W`, default 32: signature word width written to RAM.
- `RAM_AW`, default 5: RAM address width; `2^RAM_AW >= N_CHAL/WORD_W`.
- `SETTLE_CYC`, default 4: cycles the counters are held in reset per challenge (≥1).
- `WIN_CYC`, default 1024: count-window length in clk cycles (≥1).
- `HOLD_CYC`, default 2: cycles after the window closes before the comparator is sampled (≥1).

Ports:
- `clk` in, 1: system clock; the only clock.
- `rst` in, 1: synchronous, active-low reset.
- `start` in, 1: begin a sweep; sampled only in IDLE.
- `abort` in, 1: synchronous sweep abort.
- `comp_in` in, 1: comparator result (count0 vs count1).
- `busy` out, 1: high from the first SETTLE cycle through the DONE cycle.
- `done` out, 1: one-cycle completion pulse.
- `challenge` out, `CHAL_W`: mux select, registered.
- `ro_en` out, 1: RO enable; equals `busy`.
- `cnt_rst` out, 1: counter clear; high in SETTLE.
- `cnt_en` out, 1: counter enable; high in COUNT.
- `ram_addr` out, `RAM_AW`: word address.
- `ram_data` out, `WORD_W`: packed signature word.
- `ram_wren` out, 1: one-cycle write strobe.

## Operation
- States: IDLE, SETTLE, COUNT, HOLD, WRITE, DONE. Every output is registered and decoded from the state.
- IDLE: if `start`=1, go to SETTLE with `challenge`=0, `ram_addr`=0, bit index=0.
- SETTLE: `cnt_rst`=1 for `SETTLE_CYC` cycles, then go to COUNT.
- COUNT: `cnt_en`=1 for `WIN_CYC` cycles, then go to HOLD.
- HOLD: lasts `HOLD_CYC` cycles, so the RO-domain counters finish their last edges.
- On the edge that ends the last HOLD cycle:
  - word ← {word[WORD_W-2:0], `comp_in`}.
  - If bit index = `WORD_W`-1, go to WRITE.
  - Otherwise increment the bit index and `challenge`, and go to SETTLE.
- Bit packing: the first challenge of each word ends up in the word MSB.
- WRITE: one cycle with `ram_wren`=1, `ram_data`=word and `ram_addr`=word index. On exit:
  - `ram_addr`++ and bit index←0.
  - If `challenge` = `N_CHAL`-1, go to DONE with `challenge`←0.
  - Otherwise `challenge`++ and go to SETTLE.
- DONE: `done`=1 for one cycle, then go to IDLE.
- `start` is ignored outside IDLE. If `start` is held high, a new sweep begins on the cycle after DONE returns to IDLE.
- `abort`=1 in any non-IDLE state:
  - Next state is IDLE; no further `ram_wren`, no `done`.
  - `challenge`, `ram_addr` and the bit index are cleared.
  - A partial word is discarded.
- `abort` has priority over every state transition. `abort` in IDLE has no effect; if `abort` and `start` are both high in IDLE, `start` wins.
- `ram_data` holds its last written value outside WRITE.

## Timing
- Reset (`rst`=0 at an edge): state=IDLE. All outputs are 0: `busy`, `done`, `challenge`, `ro_en`, `cnt_rst`, `cnt_en`, `ram_addr`, `ram_data`, `ram_wren`. The word register is also cleared.
- Reset mid-sweep behaves like `abort` and additionally clears `ram_data`.
- `start` sampled at edge E gives `busy`, `ro_en` and `cnt_rst` = 1 in the cycle after E.
- Per challenge: `SETTLE_CYC` + `WIN_CYC` + `HOLD_CYC` cycles, plus 1 WRITE cycle per word.
- `done` is high exactly `N_CHAL`·(S+W+H) + `N_CHAL`/`WORD_W` + 1 cycles after E; `busy` drops in the following cycle.
- `comp_in` is sampled only at the final HOLD edge; its value at all other times is don't-care.
- `cnt_rst` and `cnt_en` are never high in the same cycle. There is no gap between SETTLE and COUNT.

## Test plan
Bench parameters: `N_CHAL`=8, `WORD_W`=4, `CHAL_W`=3, `RAM_AW`=1, S=2, W=8, H=2.

1. `rst`=0 for 3 cycles with `start`=1 → all outputs 0 during reset. The sweep starts only after `rst`=1, with the first cycle showing `cnt_rst`=1 and `challenge`=0.
2. `comp_in`=`challenge`[0] (i.e. 0,1,0,1,…) → RAM writes addr0=4'b0101 and addr1=4'b0101. Exactly 2 `ram_wren` pulses. `done` is high 99 cycles after the start edge, for one cycle.
3. Same sweep, check per challenge → `cnt_rst` high 2 cycles, then `cnt_en` high 8 cycles, then 2 HOLD cycles. `challenge` steps 0..7 and returns to 0 at DONE. `ro_en`=`busy` throughout.
4. `comp_in` toggling every cycle except the final HOLD cycle, where it is 1 → every stored bit is 1; RAM words are 4'b1111.
5. `start` pulsed mid-sweep → no effect on the sequence. `start` held high → IDLE lasts 1 cycle after DONE, then a second identical sweep runs.
6. `abort` during COUNT of challenge 5 → IDLE next cycle with `busy`=0 and `challenge`=0. No write to addr1, no `done`. A new `start` writes addr0 first.

Source files
------------

// File: rtl/puf_sig_sequencer_if.sv
// Sequencer <-> RO-PUF datapath bundle: control/status, counter controls and signature RAM write port.
// The sequencer takes the master side; the datapath/RAM/controller side takes slave.
interface puf_sig_sequencer_if #(
    parameter int CHAL_W = 8,
    parameter int WORD_W = 32,
    parameter int RAM_AW = 5
) ();
    logic              start;
    logic              abort;
    logic              comp_in;
    logic              busy;
    logic              done;
    logic [CHAL_W-1:0] challenge;
    logic              ro_en;
    logic              cnt_rst;
    logic              cnt_en;
    logic [RAM_AW-1:0] ram_addr;
    logic [WORD_W-1:0] ram_data;
    logic              ram_wren;

    modport master (
        input  start, abort, comp_in,
        output busy, done, challenge, ro_en, cnt_rst, cnt_en,
        output ram_addr, ram_data, ram_wren
    );

    modport slave (
        output start, abort, comp_in,
        input  busy, done, challenge, ro_en, cnt_rst, cnt_en,
        input  ram_addr, ram_data, ram_wren
    );
endinterface

// File: rtl/puf_sig_sequencer.sv
// RO-PUF signature sweep: per challenge settle/count/hold, pack comparator bits MSB-first into RAM words.
// Latency N_CHAL*(S+W+H) + N_CHAL/WORD_W + 1 cycles start-to-done; no backpressure, abort stops at once.
module puf_sig_sequencer #(
    parameter int N_CHAL     = 256,
    parameter int CHAL_W     = 8,
    parameter int WORD_W     = 32,
    parameter int RAM_AW     = 5,
    parameter int SETTLE_CYC = 4,
    parameter int WIN_CYC    = 1024,
    parameter int HOLD_CYC   = 2
) (
    input logic                clk,
    input logic                rst,
    puf_sig_sequencer_if.master bus
);
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETTLE = 3'd1;
    localparam logic [2:0] ST_COUNT  = 3'd2;
    localparam logic [2:0] ST_HOLD   = 3'd3;
    localparam logic [2:0] ST_WRITE  = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    localparam int MAX_PH = (WIN_CYC > SETTLE_CYC) ?
                            ((WIN_CYC > HOLD_CYC) ? WIN_CYC : HOLD_CYC) :
                            ((SETTLE_CYC > HOLD_CYC) ? SETTLE_CYC : HOLD_CYC);
    localparam int CYC_W  = (MAX_PH > 1) ? $clog2(MAX_PH) : 1;
    localparam int BIT_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [CYC_W-1:0]  cyc;
    logic [BIT_W-1:0]  bit_idx;
    logic [WORD_W-1:0] word;
    logic [WORD_W-1:0] word_nxt;
    logic              phase_end;
    logic              last_bit;
    logic              last_chal;
    logic              abort_hit;

    assign last_bit  = (bit_idx == BIT_W'(WORD_W - 1));
    assign last_chal = (bus.challenge == CHAL_W'(N_CHAL - 1));
    assign abort_hit = bus.abort && (state != ST_IDLE);
    assign word_nxt  = (word << 1) | {{(WORD_W-1){1'b0}}, bus.comp_in};

    always_comb begin
        phase_end = 1'b0;
        case (state)
            ST_SETTLE: phase_end = (cyc == CYC_W'(SETTLE_CYC - 1));
            ST_COUNT:  phase_end = (cyc == CYC_W'(WIN_CYC - 1));
            ST_HOLD:   phase_end = (cyc == CYC_W'(HOLD_CYC - 1));
            default:   phase_end = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (bus.start) state_nxt = ST_SETTLE;
            ST_SETTLE: if (phase_end) state_nxt = ST_COUNT;
            ST_COUNT:  if (phase_end) state_nxt = ST_HOLD;
            ST_HOLD:   if (phase_end) state_nxt = last_bit ? ST_WRITE : ST_SETTLE;
            ST_WRITE:  state_nxt = last_chal ? ST_DONE : ST_SETTLE;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
        if (abort_hit) state_nxt = ST_IDLE;
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= ST_IDLE;
            cyc           <= '0;
            bit_idx       <= '0;
            word          <= '0;
            bus.busy      <= 1'b0;
            bus.ro_en     <= 1'b0;
            bus.cnt_rst   <= 1'b0;
            bus.cnt_en    <= 1'b0;
            bus.ram_wren  <= 1'b0;
            bus.done      <= 1'b0;
            bus.challenge <= '0;
            bus.ram_addr  <= '0;
            bus.ram_data  <= '0;
        end else begin
            state        <= state_nxt;
            bus.busy     <= (state_nxt != ST_IDLE);
            bus.ro_en    <= (state_nxt != ST_IDLE);
            bus.cnt_rst  <= (state_nxt == ST_SETTLE);
            bus.cnt_en   <= (state_nxt == ST_COUNT);
            bus.ram_wren <= (state_nxt == ST_WRITE);
            bus.done     <= (state_nxt == ST_DONE);

            if ((state_nxt == state) && (state != ST_IDLE))
                cyc <= cyc + 1'b1;
            else
                cyc <= '0;

            if (abort_hit) begin
                bus.challenge <= '0;
                bus.ram_addr  <= '0;
                bit_idx       <= '0;
                word          <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (bus.start) begin
                            bus.challenge <= '0;
                            bus.ram_addr  <= '0;
                            bit_idx       <= '0;
                        end
                    end
                    ST_HOLD: begin
                        if (phase_end) begin
                            word <= word_nxt;
                            if (last_bit) begin
                                bus.ram_data <= word_nxt;
                            end else begin
                                bit_idx       <= bit_idx + 1'b1;
                                bus.challenge <= bus.challenge + 1'b1;
                            end
                        end
                    end
                    ST_WRITE: begin
                        bus.ram_addr  <= bus.ram_addr + 1'b1;
                        bit_idx       <= '0;
                        bus.challenge <= last_chal ? '0 : bus.challenge + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_puf_sig_sequencer.sv
// Scoreboarded bench: cycle-accurate schedule model for control outputs, queue of expected RAM writes.
module tb_puf_sig_sequencer;
    localparam int N_CHAL = 8;
    localparam int WORD_W = 4;
    localparam int CHAL_W = 3;
    localparam int RAM_AW = 1;
    localparam int S = 2;
    localparam int W = 8;
    localparam int H = 2;
    localparam int PER = S + W + H;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    puf_sig_sequencer_if #(.CHAL_W(CHAL_W), .WORD_W(WORD_W), .RAM_AW(RAM_AW)) bus ();

    puf_sig_sequencer #(
        .N_CHAL(N_CHAL), .CHAL_W(CHAL_W), .WORD_W(WORD_W), .RAM_AW(RAM_AW),
        .SETTLE_CYC(S), .WIN_CYC(W), .HOLD_CYC(H)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int wr_cnt = 0;
    int t      = 0;
    logic [7:0] sb[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0d, %0t)", tag, got, exp, t, $time);
    endtask

    function automatic logic [15:0] obs();
        return {6'b0, bus.busy, bus.ro_en, bus.cnt_rst, bus.cnt_en, bus.ram_wren, bus.done,
                bus.ram_addr, bus.challenge};
    endfunction

    function automatic logic [15:0] mk(input logic b, input logic r, input logic e, input logic wr,
                                       input logic dn, input logic a, input logic [2:0] ch);
        return {6'b0, b, b, r, e, wr, dn, a, ch};
    endfunction

    always @(negedge clk) begin
        if (rst && bus.ram_wren) begin
            wr_cnt++;
            chk("wr_pending", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) chk("wr_addr_data", 32'({bus.ram_addr, bus.ram_data}), 32'(sb.pop_front()));
        end
    end

    // One cycle: check the outputs of the cycle just entered, then drive inputs for its closing edge.
    task automatic step(input logic [15:0] exp, input bit keep_start, input bit final_hold,
                        input logic bit_val, input int mode);
        @(negedge clk);
        t++;
        chk("cycle_outputs", 32'(obs()), 32'(exp));
        if (!keep_start) bus.start = (t == 30);
        if (mode == 1) bus.comp_in = final_hold ? 1'b1 : ~bus.comp_in;
        else           bus.comp_in = final_hold ? bit_val : 1'($urandom_range(0, 1));
    endtask

    // mode 0: bit = challenge LSB, mode 1: toggling comp_in with 1 at the sample edge, mode 2: random bits.
    task automatic sweep(input int mode, input bit keep_start, input int abort_chal);
        logic [3:0] w;
        logic       b;
        logic       a;
        w = '0;
        t = 0;
        bus.start = 1'b1;
        for (int c = 0; c < N_CHAL; c++) begin
            b = (mode == 0) ? c[0] : (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            a = 1'((c / WORD_W) % 2);
            for (int p = 0; p < PER; p++) begin
                step(mk(1'b1, p < S, (p >= S) && (p < S + W), 1'b0, 1'b0, a, c[2:0]),
                     keep_start, p == PER - 1, b, mode);
                if (c == abort_chal && p == S + 3) begin
                    bus.abort = 1'b1;
                    step(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0), keep_start, 1'b0, 1'b0, mode);
                    bus.abort = 1'b0;
                    return;
                end
            end
            w = {w[2:0], b};
            if (c % WORD_W == WORD_W - 1) begin
                sb.push_back({3'b0, a, w});
                step(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, a, c[2:0]), keep_start, 1'b0, 1'b0, mode);
            end
        end
        step(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0), keep_start, 1'b0, 1'b0, mode);
        step(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0), keep_start, 1'b0, 1'b0, mode);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        bus.start   = 1'b1;
        bus.abort   = 1'b0;
        bus.comp_in = 1'b0;
        rst         = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("reset_outputs", 32'(obs()), 32'd0);
            chk("reset_ram_data", 32'(bus.ram_data), 32'd0);
        end
        rst = 1'b1;

        sweep(0, 1'b0, -1);
        chk("sweep0_writes", 32'(wr_cnt), 32'd2);
        chk("sweep0_sb_empty", 32'(sb.size()), 32'd0);

        wr_cnt = 0;
        sweep(1, 1'b0, -1);
        chk("sweep1_writes", 32'(wr_cnt), 32'd2);

        wr_cnt = 0;
        sweep(0, 1'b1, -1);
        sweep(0, 1'b0, -1);
        chk("held_start_writes", 32'(wr_cnt), 32'd4);
        chk("held_start_sb_empty", 32'(sb.size()), 32'd0);

        wr_cnt = 0;
        sweep(2, 1'b0, 5);
        repeat (5) begin
            @(negedge clk);
            chk("post_abort_idle", 32'(obs()), 32'd0);
        end
        chk("abort_writes", 32'(wr_cnt), 32'd1);
        chk("abort_sb_empty", 32'(sb.size()), 32'd0);

        wr_cnt = 0;
        sweep(2, 1'b0, -1);
        chk("restart_writes", 32'(wr_cnt), 32'd2);
        chk("restart_sb_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
